// File: rtl/bar_arb_pkg.sv
// Shared state encoding, width defaults and index helper for bar_arbiter.
package bar_arb_pkg;

  localparam int NREQ_DEF   = 2;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int NREQ_MAX   = 4;
  localparam int IDX_W      = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t ISSUE   = 2'd1;
  localparam state_t WAIT_RD = 2'd2;
  localparam state_t RESP    = 2'd3;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bar_arbiter_rr_grant.sv
// Grant selection: rotating search from last_grant+1, or fixed lowest-index-first
// when fixed_prio is set. Purely combinational, one-hot or zero output.
module bar_rr_grant
  import bar_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             fixed_prio,
  output logic [NREQ-1:0]  grant
);

  int   search_base;
  logic found;

  always_comb begin
    grant       = '0;
    found       = 1'b0;
    search_base = fixed_prio ? 0 : (int'(last_grant) + 1) % NREQ;
    // Scan positions in priority order; the first valid requester takes the grant.
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == (search_base + k) % NREQ)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bar_arbiter.sv
// Shares one BAR register port among NREQ requesters, one command in flight.
// Define BAR_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module bar_arbiter
  import bar_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [ADDR_W-1:0]      bar_addr,
  output logic [DATA_W-1:0]      bar_wdata,
  output logic                   bar_wen,
  output logic                   bar_ren,
  input  logic [DATA_W-1:0]      bar_rdata
);

  state_t              state;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    last_grant;
  logic                cmd_write;
  logic                fixed_prio;
  logic                handshake;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     owner_onehot;
  logic [NREQ_MAX-1:0] grant_ext;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;

  bar_rr_grant #(.NREQ(NREQ)) u_grant (
    .req        (req_valid),
    .last_grant (last_grant),
    .fixed_prio (fixed_prio),
    .grant      (grant)
  );

`ifdef BAR_ARB_FIXED_PRIO_EN
  assign fixed_prio = 1'b1;
  assign last_grant = IDX_W'(NREQ - 1);
`else
  assign fixed_prio = 1'b0;
  always_ff @(posedge clk) begin
    if (rst)            last_grant <= IDX_W'(NREQ - 1);
    else if (handshake) last_grant <= onehot_to_idx(grant_ext);
  end
`endif

  // Ready is masked during reset so no command can be accepted into a clearing FSM.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign handshake = |(req_valid & req_ready);

  always_comb begin
    grant_ext            = '0;
    grant_ext[NREQ-1:0]  = grant;
    sel_addr             = '0;
    sel_wdata            = '0;
    sel_write            = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  always_comb begin
    owner_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      owner_onehot[i] = (owner == IDX_W'(i));
    end
  end

  // bar_addr/bar_wdata double as the command registers, so they hold between commands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      cmd_write <= 1'b0;
      bar_addr  <= '0;
      bar_wdata <= '0;
      bar_wen   <= 1'b0;
      bar_ren   <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      bar_wen   <= 1'b0;
      bar_ren   <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (handshake) begin
            owner     <= onehot_to_idx(grant_ext);
            cmd_write <= sel_write;
            bar_addr  <= sel_addr;
            bar_wdata <= sel_wdata;
            bar_wen   <= sel_write;
            bar_ren   <= !sel_write;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_write) begin
            rsp_valid <= owner_onehot;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            state     <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          rsp_valid <= owner_onehot;
          rsp_rdata <= bar_rdata;
          state     <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bar_arbiter.sv
// Randomised and directed bench for bar_arbiter against a cycle-timeline reference model.
module tb_bar_arbiter;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic [ADDR_W-1:0]      bar_addr;
  logic [DATA_W-1:0]      bar_wdata;
  logic                   bar_wen;
  logic                   bar_ren;
  logic [DATA_W-1:0]      bar_rdata;

  bar_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .bar_addr  (bar_addr),
    .bar_wdata (bar_wdata),
    .bar_wen   (bar_wen),
    .bar_ren   (bar_ren),
    .bar_rdata (bar_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endfunction

  // Downstream register file: registered read data, random junk when not reading.
  logic [31:0] mem    [0:63];
  logic [31:0] shadow [0:63];

  always @(posedge clk) begin
    if (bar_wen) mem[bar_addr[7:2]] <= bar_wdata;
    bar_rdata <= bar_ren ? mem[bar_addr[7:2]] : $urandom;
  end

  // Reference model: every handshake at cycle T becomes a strobe at T+1 and a
  // response at T+2 (write) or T+3 (read); the port is free again after the response.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    int w;
    w = -1;
`ifdef BAR_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) if (v[i]) w = i;
`else
    for (int k = NREQ; k >= 1; k--) if (v[(last + k) % NREQ]) w = (last + k) % NREQ;
`endif
    return w;
  endfunction

  bit          m_init = 0;
  int          m_last, m_free;
  bit          p_act;
  int          p_issue, p_resp, p_own;
  bit          p_wr;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;

  initial begin
    forever begin
      logic [NREQ-1:0] er, ersp;
      bit ewen, eren;
      int w;
      @(negedge clk);
      if (m_init) begin
        if (p_act && cyc == p_issue) begin
          m_addr  = p_addr;
          m_wdata = p_wdata;
        end
        if (p_act && cyc == p_resp) m_rdata = p_rdata;
        ewen = p_act && cyc == p_issue && p_wr;
        eren = p_act && cyc == p_issue && !p_wr;
        ersp = (p_act && cyc == p_resp) ? (NREQ'(1) << p_own) : '0;
        er = '0;
        w  = -1;
        if (!rst && cyc >= m_free) begin
          w = pick(req_valid, m_last);
          if (w >= 0) er = NREQ'(1) << w;
        end
        chk("m_ready", 64'(req_ready), 64'(er));
        chk("m_wen", 64'(bar_wen), 64'(ewen));
        chk("m_ren", 64'(bar_ren), 64'(eren));
        chk("m_addr", 64'(bar_addr), 64'(m_addr));
        chk("m_wdata", 64'(bar_wdata), 64'(m_wdata));
        chk("m_rsp_valid", 64'(rsp_valid), 64'(ersp));
        chk("m_rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        if (w >= 0) begin
          p_act   = 1;
          p_own   = w;
          p_wr    = req_write[w];
          p_addr  = req_addr[w*ADDR_W +: ADDR_W];
          p_wdata = req_wdata[w*DATA_W +: DATA_W];
          p_issue = cyc + 1;
          p_resp  = p_wr ? cyc + 2 : cyc + 3;
          p_rdata = p_wr ? 32'h0 : shadow[p_addr[7:2]];
          if (p_wr) shadow[p_addr[7:2]] = p_wdata;
          m_free  = p_resp + 1;
          m_last  = w;
        end
      end
      if (rst) begin
        m_init  = 1;
        p_act   = 0;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_last  = NREQ - 1;
        m_free  = cyc + 1;
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i]                  = wr;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  // Waits for a handshake on any requester; returns the cycle and the ready vector.
  task automatic wait_hs(output int at, output logic [NREQ-1:0] g);
    int n;
    n  = 0;
    at = -1;
    g  = '0;
    while (at < 0 && n < 50) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        at = cyc;
        g  = req_ready;
      end
      n++;
    end
    if (at < 0) chk("hs_timeout", 64'(n), 64'(0));
  endtask

  int               t1, t2, idle_hits;
  logic [NREQ-1:0]  g;
  logic [NREQ-1:0]  exp_g [4];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    mem[2]    = 32'hA5A5_0001;
    shadow[2] = 32'hA5A5_0001;
    rst       = 1'b1;
    req_valid = '1;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    set_req(0, 0, 32'h1008, 32'h0);
    set_req(1, 0, 32'h1020, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Simultaneous reads right after reset: requester 0 wins, single read timing.
    wait_hs(t1, g);
    chk("rst_winner", 64'(g), 64'(2'b01));
    next_cyc();
    req_valid = '0;
    @(negedge clk);
    chk("rd_ren", 64'(bar_ren), 64'(1));
    chk("rd_addr", 64'(bar_addr), 64'(32'h1008));
    @(negedge clk);
    chk("rd_rsp_t2", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("rd_rsp_t3", 64'(rsp_valid), 64'(2'b01));
    chk("rd_data", 64'(rsp_rdata), 64'(32'hA5A5_0001));
    next_cyc();

    // Single write from requester 1.
    set_req(1, 1, 32'h1004, 32'h0000_0001);
    req_valid = 2'b10;
    wait_hs(t1, g);
    chk("wr_grant", 64'(g), 64'(2'b10));
    next_cyc();
    req_valid = '0;
    @(negedge clk);
    chk("wr_wen", 64'(bar_wen), 64'(1));
    chk("wr_wdata", 64'(bar_wdata), 64'(1));
    @(negedge clk);
    chk("wr_rsp", 64'(rsp_valid), 64'(2'b10));
    chk("wr_rdata", 64'(rsp_rdata), 64'(0));
    @(negedge clk);
    chk("wr_rsp_pulse", 64'(rsp_valid), 64'(0));
    next_cyc();

    // Contention: both hold valid reads.
`ifdef BAR_ARB_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    set_req(0, 0, 32'h1000, 32'h0);
    set_req(1, 0, 32'h1010, 32'h0);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_hs(t1, g);
      chk("cont_grant", 64'(g), 64'(exp_g[k]));
    end
    next_cyc();
    req_valid = '0;
    repeat (6) next_cyc();

    // Back-to-back read then write from requester 0.
    set_req(0, 0, 32'h1014, 32'hDEAD_BEEF);
    req_valid = 2'b01;
    wait_hs(t1, g);
    next_cyc();
    set_req(0, 1, 32'h100C, 32'hDEAD_BEEF);
    wait_hs(t2, g);
    chk("b2b_gap", 64'(t2 - t1), 64'(4));
    next_cyc();
    req_valid = '0;
    repeat (5) next_cyc();

    // Reset while waiting for read data.
    set_req(0, 0, 32'h1008, 32'h0);
    req_valid = 2'b01;
    wait_hs(t1, g);
    next_cyc();
    req_valid = '0;
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp", 64'(rsp_valid), 64'(0));
    chk("abort_addr", 64'(bar_addr), 64'(0));
    chk("abort_wdata", 64'(bar_wdata), 64'(0));
    chk("abort_ren", 64'(bar_ren), 64'(0));
    next_cyc();
    req_valid = 2'b01;
    wait_hs(t1, g);
    next_cyc();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_rsp", 64'(rsp_valid), 64'(2'b01));
    chk("post_rst_data", 64'(rsp_rdata), 64'(32'hA5A5_0001));
    next_cyc();

    // Idle for 100 cycles.
    idle_hits = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bar_wen || bar_ren || (|rsp_valid)) idle_hits++;
    end
    chk("idle_quiet", 64'(idle_hits), 64'(0));
    next_cyc();

    // Random traffic with occasional resets; the model checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom), 32'h1000 + 32'($urandom_range(0, 15)) * 4, $urandom);
      rst = ($urandom_range(0, 199) == 0);
      next_cyc();
    end
    rst       = 1'b0;
    req_valid = '0;
    repeat (10) next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
